// File: rtl/rc4_key_search_core_if.sv
// rtl/rc4_key_search_core_if.sv - control, ciphertext ROM and result RAM bundle for rc4_key_search_core
`timescale 1ns/1ps
interface rc4_key_search_core_if #(
  parameter int AW        = 5,
  parameter int KEY_WIDTH = 24
);
  logic                 start;
  logic                 stop;
  logic [AW-1:0]        ct_addr;
  logic [7:0]           ct_q;
  logic [AW-1:0]        pt_addr;
  logic [7:0]           pt_data;
  logic                 pt_wren;
  logic                 busy;
  logic                 done;
  logic                 found;
  logic [KEY_WIDTH-1:0] key_out;
  logic [KEY_WIDTH-1:0] cur_key;

  modport master (
    input  start, stop, ct_q,
    output ct_addr, pt_addr, pt_data, pt_wren, busy, done, found, key_out, cur_key
  );

  modport slave (
    output start, stop, ct_q,
    input  ct_addr, pt_addr, pt_data, pt_wren, busy, done, found, key_out, cur_key
  );
endinterface

// File: rtl/rc4_key_search_core.sv
// rtl/rc4_key_search_core.sv - RC4 brute-force key search: init, key schedule, decrypt and check per candidate
`timescale 1ns/1ps
module rc4_key_search_core #(
  parameter int                     KEY_BYTES = 3,
  parameter int                     MSG_LEN   = 32,
  parameter logic [8*KEY_BYTES-1:0] KEY_START = '0,
  parameter logic [8*KEY_BYTES-1:0] KEY_STEP  = (8*KEY_BYTES)'(1),
  parameter logic [8*KEY_BYTES-1:0] KEY_LIMIT = (8*KEY_BYTES)'(24'h3FFFFF)
) (
  input  logic                    clk,
  input  logic                    rst,
  rc4_key_search_core_if.master   bus
);
  localparam int KW  = 8 * KEY_BYTES;
  localparam int AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(MSG_LEN - 1);
  localparam logic [KIW-1:0] LAST_KIDX = KIW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_PRGA, S_NEXT, S_FINISH} state_t;

  state_t         state_q, state_d;
  logic [2:0]     ph_q, ph_d;
  logic [7:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KIW-1:0] kidx_q, kidx_d;
  logic           match_q, match_d;
  logic [AW-1:0]  ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d;
  logic [7:0]     pt_data_q, pt_data_d;
  logic           pt_wren_q, pt_wren_d, busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [KW-1:0]  key_out_q, key_out_d, cur_key_q, cur_key_d;

  logic [7:0]     s_mem [256];
  logic [7:0]     s_rd_q, s_rd_d;
  logic           s_we;
  logic [7:0]     s_waddr, s_wdata, s_raddr;

  logic [7:0]     key_byte, i_inc, j_ksa, j_prga;
  logic [KW:0]    key_sum;
  logic           pt_ok;

  assign s_rd_d  = s_mem[s_raddr];
  assign i_inc   = i_q + 8'd1;
  assign j_ksa   = j_q + s_rd_q + key_byte;
  assign j_prga  = j_q + s_rd_q;
  assign key_sum = {1'b0, cur_key_q} + {1'b0, KEY_STEP};
  assign pt_ok   = (pt_data_q == 8'd32) || ((pt_data_q >= 8'd97) && (pt_data_q <= 8'd122));

  // Key byte 0 is the most significant byte of the candidate.
  always_comb begin
    key_byte = cur_key_q[KW-1 -: 8];
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KIW'(b)) key_byte = cur_key_q[KW-1-8*b -: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    kidx_d    = kidx_q;
    match_d   = match_q;
    ct_addr_d = ct_addr_q;
    pt_addr_d = pt_addr_q;
    pt_data_d = pt_data_q;
    pt_wren_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    key_out_d = key_out_q;
    cur_key_d = cur_key_q;
    s_we      = 1'b0;
    s_waddr   = i_q;
    s_wdata   = i_q;
    s_raddr   = i_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          found_d   = 1'b0;
          key_out_d = '0;
          cur_key_d = KEY_START;
          busy_d    = 1'b1;
          i_d       = 8'd0;
          ph_d      = 3'd0;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        s_we    = 1'b1;
        j_d     = 8'd0;
        kidx_d  = '0;
        match_d = 1'b0;
        i_d     = i_inc;
        ph_d    = 3'd0;
        if (i_q == 8'hFF) state_d = S_KSA;
      end
      S_KSA: begin
        ph_d = ph_q + 3'd1;
        case (ph_q)
          3'd0: s_raddr = i_q;
          3'd1: begin
            si_d    = s_rd_q;
            j_d     = j_ksa;
            s_raddr = j_ksa;
          end
          3'd2: sj_d = s_rd_q;
          3'd3: begin
            s_we    = 1'b1;
            s_waddr = i_q;
            s_wdata = sj_q;
          end
          3'd4: begin
            s_we    = 1'b1;
            s_waddr = j_q;
            s_wdata = si_q;
          end
          default: begin
            ph_d   = 3'd0;
            i_d    = i_inc;
            kidx_d = (kidx_q == LAST_KIDX) ? '0 : kidx_q + KIW'(1);
            if (i_q == 8'hFF) begin
              j_d       = 8'd0;
              ct_addr_d = '0;
              state_d   = S_PRGA;
            end
          end
        endcase
      end
      S_PRGA: begin
        ph_d = ph_q + 3'd1;
        case (ph_q)
          3'd0: begin
            s_raddr = i_inc;
            i_d     = i_inc;
          end
          3'd1: begin
            si_d    = s_rd_q;
            j_d     = j_prga;
            s_raddr = j_prga;
          end
          3'd2: sj_d = s_rd_q;
          3'd3: begin
            s_we    = 1'b1;
            s_waddr = i_q;
            s_wdata = sj_q;
          end
          3'd4: begin
            s_we    = 1'b1;
            s_waddr = j_q;
            s_wdata = si_q;
          end
          3'd5: s_raddr = si_q + sj_q;
          3'd6: begin
            pt_data_d = s_rd_q ^ bus.ct_q;
            pt_addr_d = ct_addr_q;
            pt_wren_d = 1'b1;
          end
          default: begin
            // The byte being written this cycle is checked here, so a bad byte aborts at once.
            ph_d = 3'd0;
            if (!pt_ok) begin
              state_d = S_NEXT;
            end else if (ct_addr_q == LAST_ADDR) begin
              match_d = 1'b1;
              state_d = S_NEXT;
            end else begin
              ct_addr_d = ct_addr_q + AW'(1);
            end
          end
        endcase
      end
      S_NEXT: begin
        if (match_q || (key_sum > {1'b0, KEY_LIMIT})) begin
          state_d = S_FINISH;
        end else begin
          cur_key_d = key_sum[KW-1:0];
          i_d       = 8'd0;
          state_d   = S_INIT;
        end
      end
      S_FINISH: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        found_d   = match_q;
        key_out_d = match_q ? cur_key_q : '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.stop && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      ph_d      = 3'd0;
      busy_d    = 1'b0;
      pt_wren_d = 1'b0;
      done_d    = 1'b0;
      found_d   = found_q;
      key_out_d = key_out_q;
      s_we      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_waddr] <= s_wdata;
    s_rd_q <= s_rd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= 3'd0;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      kidx_q    <= '0;
      match_q   <= 1'b0;
      ct_addr_q <= '0;
      pt_addr_q <= '0;
      pt_data_q <= 8'd0;
      pt_wren_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      key_out_q <= '0;
      cur_key_q <= KEY_START;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      kidx_q    <= kidx_d;
      match_q   <= match_d;
      ct_addr_q <= ct_addr_d;
      pt_addr_q <= pt_addr_d;
      pt_data_q <= pt_data_d;
      pt_wren_q <= pt_wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      key_out_q <= key_out_d;
      cur_key_q <= cur_key_d;
    end
  end

  assign bus.ct_addr = ct_addr_q;
  assign bus.pt_addr = pt_addr_q;
  assign bus.pt_data = pt_data_q;
  assign bus.pt_wren = pt_wren_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.found   = found_q;
  assign bus.key_out = key_out_q;
  assign bus.cur_key = cur_key_q;
endmodule

// File: doc/rc4_key_search_core.md
# rc4_key_search_core

Parametrised RC4 brute-force key-search engine: for each candidate key it initialises an internal 256-byte S array, runs the key-scheduling shuffle, decrypts a MSG_LEN-byte ciphertext from an external ROM into an external result RAM, and checks every plaintext byte on the fly. It succeeds the single-key init/shuffle/decrypt/check chain under the de1soc top and collapses that chain into one block. It adds configurable key width and message length, and key-space striding (KEY_START/KEY_STEP) so N instances can partition the search. It also adds early abort on the first bad character.

## Interface
- KEY_BYTES, 3: key length in bytes; KEY_WIDTH = 8*KEY_BYTES.
- MSG_LEN, 32: ciphertext/plaintext length in bytes, 1..256.
- KEY_START, 0: first candidate key.
- KEY_STEP, 1: candidate increment, ≥1.
- KEY_LIMIT, 24'h3FFFFF: last legal candidate, inclusive.
- AW: derived, $clog2(MSG_LEN), minimum 1.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request that begins a search at KEY_START.
- stop  in  1  aborts a search in progress.
- ct_addr  out  AW  ciphertext ROM address.
- ct_q  in  8  ROM data, valid 1 cycle after ct_addr.
- pt_addr  out  AW  result RAM address.
- pt_data  out  8  decrypted byte.
- pt_wren  out  1  result RAM write enable.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse when the search ends.
- found  out  1  valid from done until the next accepted start.
- key_out  out  KEY_WIDTH  matching key; 0 when found=0.
- cur_key  out  KEY_WIDTH  candidate currently under test, used for display.

## Operation
- Key byte k (k=0..KEY_BYTES-1) = key[KEY_WIDTH-1-8k -: 8]. Index i uses byte i mod KEY_BYTES.
- S is an internal 256x8 synchronous-read RAM, with read data 1 cycle after the address. All index arithmetic is mod 256 (8-bit wrap).
- FSM states: IDLE → INIT → KSA → PRGA → NEXT → (INIT | FINISH) → IDLE.
- IDLE: start accepted only here. The cycle start is accepted:
  - clear found and key_out;
  - load cur_key=KEY_START.
- INIT: S[i]=i for i=0..255. Clear j.
- KSA: for i=0..255:
  - j = j + S[i] + key[i mod KEY_BYTES];
  - swap S[i], S[j].
- PRGA: i=0, j=0. For k=0..MSG_LEN-1:
  - i=i+1; j=j+S[i]; swap S[i], S[j];
  - f=S[S[i]+S[j]];
  - pt=f ^ ct_q at ct_addr=k;
  - write pt to pt_addr=k with pt_wren=1 for exactly one cycle.
- Byte check, same cycle as the write: legal iff pt==8'd32 or 8'd97≤pt≤8'd122.
  - Illegal byte: go to NEXT immediately; remaining bytes are not processed.
  - All MSG_LEN bytes legal: go to FINISH with found=1, key_out=cur_key.
- NEXT: compute cur_key+KEY_STEP in KEY_WIDTH+1 bits.
  - Sum > KEY_LIMIT: go to FINISH with found=0.
  - Otherwise: update cur_key and return to INIT.
- FINISH: done=1 for one cycle, then IDLE.
- Partial plaintext from rejected keys stays in the result RAM. Only the final RAM contents are meaningful when found=1.

## Timing
- Reset values:
  - pt_wren, done, found, busy: 0.
  - key_out: 0; cur_key: KEY_START.
  - ct_addr, pt_addr, pt_data: 0.
  - FSM in IDLE; S contents undefined.
- rst dominates start and stop in the same cycle. Reset mid-search returns to IDLE next cycle with no done pulse.
- Fixed per-candidate cost:
  - INIT: 256 cycles.
  - KSA: 6 cycles per i (1536 total).
  - PRGA: 8 cycles per byte checked.
  - NEXT: 1 cycle.
- A key rejected at byte k costs 1793+8(k+1) cycles.
- Full-match latency from the start cycle to the done pulse is 1+N·(1793)+8·(total bytes checked)+1 cycles, where N is the number of candidates tried. These cycle counts are normative; the bench checks them.
- stop while busy: busy=0 and pt_wren=0 on the next cycle, no done pulse, found unchanged at 0. stop in IDLE has no effect. If start and stop arrive together in IDLE, stop wins.
- start while busy is ignored.
- start in the cycle right after done is accepted.
- pt_wren is never high outside PRGA.
- ct_addr is stable for ≥2 cycles before its data is consumed.
- If KEY_START > KEY_LIMIT, exactly one candidate (KEY_START) is still tested before FINISH.

## Test plan
- Reset, then idle 20 cycles -> busy=done=found=pt_wren=0, key_out=0, cur_key=KEY_START.
- ROM holds 32-byte ciphertext of "the quick brown fox jumps over t" under key 24'h000003, defaults, start -> done after exactly the cycle count from the rejection/match formula; found=1; key_out=24'h000003; result RAM equals the plaintext byte for byte.
- Same ROM, KEY_LIMIT=24'h000002 -> done with found=0, key_out=0, cur_key=24'h000002. No further pt_wren after done.
- KEY_START=1, KEY_STEP=2, ciphertext under key 24'h000005 -> candidates 1, 3, 5 observed on cur_key; found=1, key_out=24'h000005. Repeat with the key at 24'h000004 and KEY_LIMIT=6 -> found=0.
- Assert stop 300 cycles into KSA -> busy low next cycle, no done pulse. A new start then reproduces the full-match result.
- Pulse start again 10 cycles into a run, and pulse rst during PRGA -> the second start is ignored; rst returns all outputs to reset values the next cycle.
